// File: rtl/vc_packet_ctrl_if.sv
// ---------------------------------------------------------------------------
// vc_packet_ctrl_if: VC-buffer, allocator and pop signals of one packet controller.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface vc_packet_ctrl_if #(
  parameter int VC_NUM = 2
);
  localparam int VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  logic               is_empty_i;
  logic [1:0]         head_label_i;
  logic               downstream_on_i;
  logic               va_req_o;
  logic               va_grant_i;
  logic [VC_SIZE-1:0] va_vc_i;
  logic               sa_req_o;
  logic               sa_grant_i;
  logic               read_o;

  // Controller side: consumes buffer/allocator status, drives requests and pop.
  modport master (
    input  is_empty_i, head_label_i, downstream_on_i,
    input  va_grant_i, va_vc_i, sa_grant_i,
    output va_req_o, sa_req_o, read_o
  );

  modport slave (
    output is_empty_i, head_label_i, downstream_on_i,
    output va_grant_i, va_vc_i, sa_grant_i,
    input  va_req_o, sa_req_o, read_o
  );
endinterface

`default_nettype wire

// File: rtl/vc_packet_ctrl.sv
// ---------------------------------------------------------------------------
// vc_packet_ctrl: per-VC packet VA/SA sequencing and buffer pop control.
// Optional malformed-packet checking enabled by defining VC_PKT_CHECK_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vc_packet_ctrl #(
  parameter int VC_NUM    = 2,
  parameter int CNT_WIDTH = 8
) (
  input  wire logic                          clk,
  input  wire logic                          rst,
  vc_packet_ctrl_if.master                   bus,
  output logic [((VC_NUM > 1) ? $clog2(VC_NUM) : 1)-1:0] vc_o,
  output logic [CNT_WIDTH-1:0]               flit_cnt_o,
  output logic [1:0]                         state_o,
  output logic                               error_o
);
  localparam int VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  localparam logic [1:0] LBL_HEAD     = 2'd0;
  localparam logic [1:0] LBL_TAIL     = 2'd2;
  localparam logic [1:0] LBL_HEADTAIL = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_VA     = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [VC_SIZE-1:0]   vc_q, vc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic va_req, sa_req, pop, discard;
  logic is_start, is_end;

  assign is_start = (bus.head_label_i == LBL_HEAD) || (bus.head_label_i == LBL_HEADTAIL);
  assign is_end   = (bus.head_label_i == LBL_TAIL) || (bus.head_label_i == LBL_HEADTAIL);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      vc_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vc_q    <= vc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vc_d    = vc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
`ifdef VC_PKT_CHECK_EN
        if (!bus.is_empty_i && is_start) begin
`else
        if (!bus.is_empty_i) begin
`endif
          state_d = ST_VA;
          cnt_d   = '0;
        end
      end
      ST_VA: begin
        if (bus.va_grant_i) begin
          vc_d    = bus.va_vc_i;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (pop) begin
          if (cnt_q != {CNT_WIDTH{1'b1}}) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          end
          if (is_end) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Requests and pops are gated by rst so nothing leaks out while reset is held.
  always_comb begin
    va_req  = 1'b0;
    sa_req  = 1'b0;
    pop     = 1'b0;
    discard = 1'b0;
    if (rst) begin
      case (state_q)
        ST_VA: va_req = 1'b1;
        ST_ACTIVE: begin
          sa_req = ~bus.is_empty_i & bus.downstream_on_i;
          pop    = sa_req & bus.sa_grant_i;
        end
`ifdef VC_PKT_CHECK_EN
        ST_IDLE: discard = ~bus.is_empty_i & ~is_start;
`endif
        default: ;
      endcase
    end
  end

`ifdef VC_PKT_CHECK_EN
  // A head-labelled flit popped after the first one means the upstream packet was truncated.
  assign err_d = err_q | discard | (pop & (cnt_q != '0) & is_start);
`else
  assign err_d = 1'b0;
`endif

  assign bus.va_req_o = va_req;
  assign bus.sa_req_o = sa_req;
  assign bus.read_o   = pop | discard;
  assign vc_o         = vc_q;
  assign flit_cnt_o   = cnt_q;
  assign state_o      = state_q;
  assign error_o      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_vc_packet_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vc_packet_ctrl: directed scenarios plus randomized traffic against a packet-level model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vc_packet_ctrl;
  localparam int CNT_MAX = 255;
`ifdef VC_PKT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [0:0] vc_o;
  logic [7:0] flit_cnt_o;
  logic [1:0] state_o;
  logic       error_o;

  int checks   = 0;
  int failures = 0;

  int m_state = 0;
  int m_vc    = 0;
  int m_cnt   = 0;
  bit m_err   = 1'b0;
  bit e_va, e_sa, e_read;

  vc_packet_ctrl_if #(.VC_NUM(2)) bus ();

  vc_packet_ctrl #(.VC_NUM(2), .CNT_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .vc_o       (vc_o),
    .flit_cnt_o (flit_cnt_o),
    .state_o    (state_o),
    .error_o    (error_o)
  );

  always #5 clk = ~clk;

  function automatic bit starts_pkt(logic [1:0] l);
    return (l == 2'd0) || (l == 2'd3);
  endfunction

  function automatic bit ends_pkt(logic [1:0] l);
    return (l == 2'd2) || (l == 2'd3);
  endfunction

  task automatic model_eval();
    e_va   = rst && (m_state == 1);
    e_sa   = rst && (m_state == 2) && !bus.is_empty_i && bus.downstream_on_i;
    e_read = (e_sa && bus.sa_grant_i) ||
             (CHK && rst && (m_state == 0) && !bus.is_empty_i && !starts_pkt(bus.head_label_i));
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (!rst) begin
      m_state = 0; m_vc = 0; m_cnt = 0; m_err = 1'b0;
    end else if (m_state == 0) begin
      if (!bus.is_empty_i) begin
        if (!CHK || starts_pkt(bus.head_label_i)) begin
          m_state = 1; m_cnt = 0;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (m_state == 1) begin
      if (bus.va_grant_i) begin
        m_vc = int'(bus.va_vc_i); m_state = 2;
      end
    end else if (e_read) begin
      if (CHK && m_cnt > 0 && starts_pkt(bus.head_label_i)) m_err = 1'b1;
      if (m_cnt < CNT_MAX) m_cnt++;
      if (ends_pkt(bus.head_label_i)) m_state = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.is_empty_i      = 1'b1;
    bus.head_label_i    = 2'd0;
    bus.downstream_on_i = 1'b1;
    bus.va_grant_i      = 1'b0;
    bus.va_vc_i         = 1'b0;
    bus.sa_grant_i      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic to_active(input logic v);
    bus.is_empty_i = 1'b0; bus.head_label_i = 2'd0; bus.downstream_on_i = 1'b1;
    bus.sa_grant_i = 1'b0; bus.va_grant_i = 1'b0;
    tick();
    bus.va_grant_i = 1'b1; bus.va_vc_i = v;
    tick();
    bus.va_grant_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.is_empty_i = 1'b0; bus.head_label_i = 2'd0; bus.sa_grant_i = 1'b1;
    rst = 1'b0;
    tick(); tick();
    #1;
    checks++; if (bus.va_req_o !== 1'b0) begin failures++; $display("FAIL reset_va_req: got %b expected 0", bus.va_req_o); end
    checks++; if (bus.sa_req_o !== 1'b0) begin failures++; $display("FAIL reset_sa_req: got %b expected 0", bus.sa_req_o); end
    checks++; if (bus.read_o !== 1'b0) begin failures++; $display("FAIL reset_read: got %b expected 0", bus.read_o); end
    checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    checks++; if (vc_o !== 1'b0) begin failures++; $display("FAIL reset_vc: got %0d expected 0", vc_o); end
    checks++; if (flit_cnt_o !== 8'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", flit_cnt_o); end
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", error_o); end
    rst = 1'b1;
    #1;
    checks++; if (bus.va_req_o !== 1'b0) begin failures++; $display("FAIL release_va_req_early: got %b expected 0", bus.va_req_o); end
    tick();
    #1;
    checks++; if (bus.va_req_o !== 1'b1) begin failures++; $display("FAIL release_va_req: got %b expected 1", bus.va_req_o); end
    checks++; if (state_o !== 2'd1) begin failures++; $display("FAIL release_state: got %0d expected 1", state_o); end
  endtask

  task automatic test_four_flit();
    logic [1:0] lbl [4];
    lbl = '{2'd0, 2'd1, 2'd1, 2'd2};
    do_reset();
    bus.is_empty_i = 1'b0; bus.head_label_i = 2'd0; bus.sa_grant_i = 1'b1; bus.va_vc_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.va_req_o !== 1'b1 || bus.read_o !== 1'b0) begin failures++; $display("FAIL va_wait: va_req=%b read=%b expected va_req=1 read=0", bus.va_req_o, bus.read_o); end
      if (i == 2) bus.va_grant_i = 1'b1;
      tick();
    end
    bus.va_grant_i = 1'b0;
    #1;
    checks++; if (vc_o !== 1'b1) begin failures++; $display("FAIL pkt4_vc: got %0d expected 1", vc_o); end
    checks++; if (state_o !== 2'd2) begin failures++; $display("FAIL pkt4_state: got %0d expected 2", state_o); end
    for (int i = 0; i < 4; i++) begin
      bus.head_label_i = lbl[i];
      #1;
      checks++; if (bus.read_o !== 1'b1) begin failures++; $display("FAIL pkt4_read%0d: got %b expected 1", i, bus.read_o); end
      tick();
    end
    bus.is_empty_i = 1'b1;
    #1;
    checks++; if (flit_cnt_o !== 8'd4) begin failures++; $display("FAIL pkt4_cnt: got %0d expected 4", flit_cnt_o); end
    checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL pkt4_end_state: got %0d expected 0", state_o); end
    checks++; if (bus.read_o !== 1'b0) begin failures++; $display("FAIL pkt4_no_read: got %b expected 0", bus.read_o); end
  endtask

  task automatic test_headtail();
    int reads = 0;
    do_reset();
    bus.is_empty_i = 1'b0; bus.head_label_i = 2'd3; bus.va_grant_i = 1'b1; bus.va_vc_i = 1'b0; bus.sa_grant_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.read_o === 1'b1) reads++;
      tick();
      if (state_o == 2'd0 && i > 0) bus.is_empty_i = 1'b1;
    end
    bus.is_empty_i = 1'b1;
    #1;
    checks++; if (reads != 1) begin failures++; $display("FAIL ht_reads: got %0d expected 1", reads); end
    checks++; if (flit_cnt_o !== 8'd1) begin failures++; $display("FAIL ht_cnt: got %0d expected 1", flit_cnt_o); end
    checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL ht_state: got %0d expected 0", state_o); end
  endtask

  task automatic test_backpressure();
    do_reset();
    to_active(1'b0);
    bus.sa_grant_i = 1'b1; bus.head_label_i = 2'd0;
    tick();
    bus.head_label_i = 2'd1;
    tick();
    bus.downstream_on_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.sa_req_o !== 1'b0 || bus.read_o !== 1'b0) begin failures++; $display("FAIL bp_req: sa_req=%b read=%b expected 0 0", bus.sa_req_o, bus.read_o); end
      checks++; if (flit_cnt_o !== 8'd2 || state_o !== 2'd2) begin failures++; $display("FAIL bp_hold: cnt=%0d state=%0d expected 2 2", flit_cnt_o, state_o); end
      tick();
    end
    bus.downstream_on_i = 1'b1; bus.head_label_i = 2'd2;
    #1;
    checks++; if (bus.read_o !== 1'b1) begin failures++; $display("FAIL bp_resume: got %b expected 1", bus.read_o); end
    tick();
    bus.is_empty_i = 1'b1;
    #1;
    checks++; if (flit_cnt_o !== 8'd3 || state_o !== 2'd0) begin failures++; $display("FAIL bp_end: cnt=%0d state=%0d expected 3 0", flit_cnt_o, state_o); end
  endtask

  task automatic test_body_in_idle();
    do_reset();
    bus.is_empty_i = 1'b0; bus.head_label_i = 2'd1;
`ifdef VC_PKT_CHECK_EN
    #1;
    checks++; if (bus.read_o !== 1'b1) begin failures++; $display("FAIL discard_read: got %b expected 1", bus.read_o); end
    tick();
    bus.is_empty_i = 1'b1;
    #1;
    checks++; if (error_o !== 1'b1 || state_o !== 2'd0) begin failures++; $display("FAIL discard_err: err=%b state=%0d expected 1 0", error_o, state_o); end
    checks++; if (bus.read_o !== 1'b0) begin failures++; $display("FAIL discard_once: got %b expected 0", bus.read_o); end
    tick(); tick();
    #1;
    checks++; if (error_o !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b expected 1", error_o); end
`else
    tick();
    #1;
    checks++; if (bus.va_req_o !== 1'b1 || error_o !== 1'b0) begin failures++; $display("FAIL body_start: va_req=%b err=%b expected 1 0", bus.va_req_o, error_o); end
`endif
  endtask

  task automatic test_reset_midpacket();
    do_reset();
    to_active(1'b1);
    bus.sa_grant_i = 1'b1; bus.head_label_i = 2'd0;
    tick();
    bus.head_label_i = 2'd1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.read_o !== 1'b0 || bus.sa_req_o !== 1'b0) begin failures++; $display("FAIL rstmid_gate: read=%b sa_req=%b expected 0 0", bus.read_o, bus.sa_req_o); end
    tick();
    rst = 1'b1; bus.is_empty_i = 1'b1;
    #1;
    checks++; if (state_o !== 2'd0 || flit_cnt_o !== 8'd0 || vc_o !== 1'b0) begin failures++; $display("FAIL rstmid_regs: state=%0d cnt=%0d vc=%0d expected 0 0 0", state_o, flit_cnt_o, vc_o); end
  endtask

  task automatic test_random();
    logic [1:0] q[$];
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (q.size() < 8 && $urandom_range(0, 3) == 0) begin
        int len = $urandom_range(1, 5);
        if (len == 1) q.push_back(2'd3);
        else begin
          q.push_back(2'd0);
          for (int k = 1; k < len - 1; k++) q.push_back(2'd1);
          q.push_back(2'd2);
        end
      end
      rst                 = ($urandom_range(0, 199) != 0);
      bus.is_empty_i      = (q.size() == 0);
      bus.head_label_i    = (q.size() == 0) ? 2'($urandom_range(0, 3)) : q[0];
      bus.downstream_on_i = ($urandom_range(0, 3) != 0);
      bus.sa_grant_i      = ($urandom_range(0, 2) != 0);
      bus.va_grant_i      = ($urandom_range(0, 2) == 0);
      bus.va_vc_i         = 1'($urandom_range(0, 1));
      #1;
      model_eval();
      checks++; if (bus.va_req_o !== e_va) begin failures++; $display("FAIL rnd_va_req cyc %0d: got %b expected %b", cyc, bus.va_req_o, e_va); end
      checks++; if (bus.sa_req_o !== e_sa) begin failures++; $display("FAIL rnd_sa_req cyc %0d: got %b expected %b", cyc, bus.sa_req_o, e_sa); end
      checks++; if (bus.read_o !== e_read) begin failures++; $display("FAIL rnd_read cyc %0d: got %b expected %b", cyc, bus.read_o, e_read); end
      checks++; if (int'(state_o) != m_state) begin failures++; $display("FAIL rnd_state cyc %0d: got %0d expected %0d", cyc, state_o, m_state); end
      checks++; if (int'(vc_o) != m_vc) begin failures++; $display("FAIL rnd_vc cyc %0d: got %0d expected %0d", cyc, vc_o, m_vc); end
      checks++; if (int'(flit_cnt_o) != m_cnt) begin failures++; $display("FAIL rnd_cnt cyc %0d: got %0d expected %0d", cyc, flit_cnt_o, m_cnt); end
      checks++; if (error_o !== m_err) begin failures++; $display("FAIL rnd_err cyc %0d: got %b expected %b", cyc, error_o, m_err); end
      tick();
      if (e_read && q.size() > 0) void'(q.pop_front());
    end
    rst = 1'b1;
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_four_flit();
    test_headtail();
    test_backpressure();
    test_body_in_idle();
    test_reset_midpacket();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vc_packet_ctrl.md
# vc_packet_ctrl

Per-virtual-channel packet control stage sitting directly downstream of each input-port circular buffer. Watches the head flit and empty flag of one VC buffer, walks each packet through virtual-channel allocation and switch allocation, and issues the buffer read strobe that pops flits toward the crossbar. Tracks the allocated downstream VC and the downstream on/off flag, and counts flits forwarded per packet.

## Interface
Parameters:
- VC_NUM, default 2, number of downstream VCs; VC_SIZE = max(1, $clog2(VC_NUM))
- CNT_WIDTH, default 8, width of the per-packet flit counter

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- is_empty_i  in  1  VC buffer empty flag
- head_label_i  in  flit_label_t (2)  label of the flit at the buffer head (HEAD=0, BODY=1, TAIL=2, HEADTAIL=3); valid only when is_empty_i=0
- downstream_on_i  in  1  on/off flag of the allocated downstream VC (1 = may send)
- va_req_o  out  1  VC allocation request
- va_grant_i  in  1  VC allocation grant
- va_vc_i  in  VC_SIZE  downstream VC granted, sampled with va_grant_i
- sa_req_o  out  1  switch allocation request
- sa_grant_i  in  1  switch allocation grant, same-cycle response to sa_req_o
- read_o  out  1  pop strobe to the VC buffer's read input
- vc_o  out  VC_SIZE  latched downstream VC for the current packet
- flit_cnt_o  out  CNT_WIDTH  flits forwarded in the current packet
- state_o  out  2  IDLE=0, VA=1, ACTIVE=2
- error_o  out  1  sticky protocol error

## Operation
- IDLE: va_req_o=sa_req_o=0. If is_empty_i=0 and head_label_i is HEAD or HEADTAIL -> VA; flit_cnt_o cleared to 0 on this transition.
- VA: va_req_o=1. On va_grant_i=1: vc_o <= va_vc_i, -> ACTIVE. No pop while in VA.
- ACTIVE: sa_req_o = ~is_empty_i & downstream_on_i. read_o = sa_req_o & sa_grant_i. Each pop increments flit_cnt_o, saturating at all-ones. A pop with head_label_i TAIL or HEADTAIL -> IDLE (vc_o held until next grant).
- sa_grant_i without sa_req_o and va_grant_i outside VA are ignored.
- state 3 unreachable; if entered, -> IDLE next cycle.
- Reset (rst=0 at an edge, any state, including mid-packet): state IDLE, vc_o=0, flit_cnt_o=0, error_o=0. While rst=0, va_req_o, sa_req_o, read_o forced 0 combinationally.

## Timing
- Reset values: state_o=0, vc_o=0, flit_cnt_o=0, error_o=0, va_req_o=0, sa_req_o=0, read_o=0.
- Head visible in IDLE at cycle N -> va_req_o high at N+1.
- Grant at cycle M -> ACTIVE, sa_req_o eligible at M+1.
- read_o is combinational from sa_grant_i in the same cycle; buffer pops at that edge; next head_label_i evaluated next cycle.
- Tail pop at cycle T -> IDLE at T+1; next packet's HEAD earliest VA at T+2.
- downstream_on_i low: sa_req_o drops in the same cycle; no pop; state held.
- HEADTAIL: one pop, ACTIVE -> IDLE.

## Configuration
- VC_PKT_CHECK_EN defined: in IDLE a non-empty head with label BODY or TAIL sets error_o and asserts read_o for one cycle to discard it (state stays IDLE); in ACTIVE with flit_cnt_o>0, a popped HEAD or HEADTAIL-from-middle sets error_o (HEAD: packet continues; HEADTAIL: ends packet). error_o sticky until reset.
- Undefined: error_o tied 0; any non-empty head in IDLE starts a packet (-> VA), no discards.

## Test plan
- Reset: rst=0 for 2 cycles with is_empty_i=0, HEAD -> all outputs 0, state_o=0; release -> va_req_o=1 one cycle later.
- 4-flit packet (HEAD,BODY,BODY,TAIL), va_grant_i with va_vc_i=1 after 3 cycles, sa_grant_i always 1 -> vc_o=1, 4 consecutive read_o pulses, flit_cnt_o=4, state_o=0 after tail.
- HEADTAIL with grants immediate -> exactly one read_o, flit_cnt_o=1, back in IDLE next cycle.
- ACTIVE, downstream_on_i=0 for 5 cycles mid-packet -> sa_req_o=0, read_o=0, flit_cnt_o frozen; resumes when on=1.
- With VC_PKT_CHECK_EN, BODY at head in IDLE -> one read_o discard pulse, error_o=1 and stays 1; without macro -> va_req_o=1, error_o=0.
- rst=0 mid-packet after 2 pops -> state_o=0, flit_cnt_o=0, vc_o=0 next cycle.
